// File: rtl/ball_motion.sv
// Pong-style ball mover: serve, wall bounces, paddle reflection and miss scoring.
// Ball position advances by SPEED on each tick while in PLAY.
module ball_motion #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_W     = 8,
  parameter int SPEED      = 4,
  parameter int PADDLE_XL  = 16,
  parameter int PADDLE_XR  = 616,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int HOLD_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] paddle_y_left,
  input  logic [9:0] paddle_y_right,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [5:0] ball_width,
  output logic       miss_left,
  output logic       miss_right,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam int W  = 12;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic signed [W-1:0] S_SPEED = W'(SPEED);
  localparam logic signed [W-1:0] S_BW    = W'(BALL_W);
  localparam logic signed [W-1:0] S_SW    = W'(SCREEN_W);
  localparam logic signed [W-1:0] S_SH    = W'(SCREEN_H);
  localparam logic signed [W-1:0] S_XL    = W'(PADDLE_XL);
  localparam logic signed [W-1:0] S_XR    = W'(PADDLE_XR);
  localparam logic signed [W-1:0] S_PW    = W'(PADDLE_W);
  localparam logic signed [W-1:0] S_PH    = W'(PADDLE_H);
  localparam logic signed [W-1:0] MAX_X   = W'(SCREEN_W - BALL_W);
  localparam logic signed [W-1:0] MAX_Y   = W'(SCREEN_H - BALL_W);

  localparam logic [9:0]    CENTER_X = 10'((SCREEN_W - BALL_W) / 2);
  localparam logic [9:0]    CENTER_Y = 10'((SCREEN_H - BALL_W) / 2);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS - 1);

  // Saturate a signed coordinate into the on-screen range so it can never wrap.
  function automatic logic [9:0] clamp_pos(input logic signed [W-1:0] v,
                                           input logic signed [W-1:0] hi);
    logic signed [W-1:0] r;
    if (v < 0)       r = '0;
    else if (v > hi) r = hi;
    else             r = v;
    return r[9:0];
  endfunction

  state_t        state_q;
  logic          dx_right;
  logic          dy_down;
  logic          serve_dir;
  logic [HW-1:0] hold_cnt;

  logic signed [W-1:0] x, y, pyl, pyr;
  logic signed [W-1:0] nx, ny;
  logic                ndx_right, ndy_down;
  logic                hit_l, hit_r, miss_l, miss_r;

  // Next-position datapath, evaluated every cycle and consumed only on PLAY ticks.
  always_comb begin
    x   = $signed({2'b00, ball_x});
    y   = $signed({2'b00, ball_y});
    pyl = $signed({2'b00, paddle_y_left});
    pyr = $signed({2'b00, paddle_y_right});

    hit_l = !dx_right && (x - S_SPEED <= S_XL + S_PW) && (x > S_XL)
            && (y + S_BW > pyl) && (y < pyl + S_PH);
    hit_r = dx_right && (x + S_BW + S_SPEED >= S_XR) && (x + S_BW < S_XR + S_PW)
            && (y + S_BW > pyr) && (y < pyr + S_PH);
    miss_l = !dx_right && (x <= S_SPEED) && !hit_l;
    miss_r = dx_right && (x + S_BW + S_SPEED >= S_SW) && !hit_r;

    ndx_right = dx_right;
    if (hit_l) begin
      nx        = S_XL + S_PW;
      ndx_right = 1'b1;
    end else if (hit_r) begin
      nx        = S_XR - S_BW;
      ndx_right = 1'b0;
    end else if (miss_l) begin
      nx = '0;
    end else if (miss_r) begin
      nx = MAX_X;
    end else if (dx_right) begin
      nx = x + S_SPEED;
    end else begin
      nx = x - S_SPEED;
    end

    ndy_down = dy_down;
    if (!dy_down && (y <= S_SPEED)) begin
      ny       = '0;
      ndy_down = 1'b1;
    end else if (dy_down && (y + S_BW + S_SPEED >= S_SH)) begin
      ny       = MAX_Y;
      ndy_down = 1'b0;
    end else if (dy_down) begin
      ny = y + S_SPEED;
    end else begin
      ny = y - S_SPEED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ball_x     <= CENTER_X;
      ball_y     <= CENTER_Y;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      serve_dir  <= 1'b1;
      hold_cnt   <= '0;
      dx_right   <= 1'b1;
      dy_down    <= 1'b1;
    end else begin
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      case (state_q)
        IDLE: begin
          ball_x   <= CENTER_X;
          ball_y   <= CENTER_Y;
          hold_cnt <= '0;
          if (serve) begin
            state_q   <= PLAY;
            dx_right  <= serve_dir;
            dy_down   <= 1'b1;
            serve_dir <= !serve_dir;
          end
        end
        PLAY: begin
          if (tick) begin
            ball_x   <= clamp_pos(nx, MAX_X);
            ball_y   <= clamp_pos(ny, MAX_Y);
            dx_right <= ndx_right;
            dy_down  <= ndy_down;
            if (miss_l) begin
              miss_left <= 1'b1;
              state_q   <= SCORED;
            end else if (miss_r) begin
              miss_right <= 1'b1;
              state_q    <= SCORED;
            end
          end
        end
        SCORED: begin
          if (tick) begin
            if (hold_cnt == HOLD_END) begin
              state_q  <= IDLE;
              hold_cnt <= '0;
              ball_x   <= CENTER_X;
              ball_y   <= CENTER_Y;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state      = state_q;
  assign ball_width = 6'(BALL_W);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a short per-cycle vector table followed by
// long hand-counted trajectories through walls, paddles, misses and resets.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       serve;
  logic [9:0] paddle_y_left;
  logic [9:0] paddle_y_right;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [5:0] ball_width;
  logic       miss_left;
  logic       miss_right;
  logic [1:0] state;

  ball_motion dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .serve(serve),
    .paddle_y_left(paddle_y_left),
    .paddle_y_right(paddle_y_right),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .ball_width(ball_width),
    .miss_left(miss_left),
    .miss_right(miss_right),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic serve;
    logic tick;
    int   ex;
    int   ey;
    int   est;
  } vec_t;

  vec_t tbl[6];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   misses = 0;

  task automatic chk(input string name, input int ex, input int ey, input int est,
                     input int eml, input int emr);
    n_vec++;
    if (int'(ball_x) != ex || int'(ball_y) != ey || int'(state) != est ||
        int'(miss_left) != eml || int'(miss_right) != emr || int'(ball_width) != 8) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d ml=%0d mr=%0d w=%0d, expected x=%0d y=%0d st=%0d ml=%0d mr=%0d w=8",
               name, ball_x, ball_y, state, miss_left, miss_right, ball_width,
               ex, ey, est, eml, emr);
    end
  endtask

  task automatic cyc(input logic s, input logic t);
    serve = s;
    tick  = t;
    @(posedge clk);
    #1;
  endtask

  // Free-running ticks; records any miss pulse seen along the way.
  task automatic run(input int n);
    misses = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1);
      if (miss_left || miss_right) misses++;
    end
  endtask

  task automatic chk_no_miss(input string name);
    n_vec++;
    if (misses != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d miss pulses, expected 0", name, misses);
    end
  endtask

  initial begin
    tbl[0] = '{serve: 1'b0, tick: 1'b1, ex: 316, ey: 236, est: 0};
    tbl[1] = '{serve: 1'b1, tick: 1'b1, ex: 316, ey: 236, est: 1};
    tbl[2] = '{serve: 1'b0, tick: 1'b0, ex: 316, ey: 236, est: 1};
    tbl[3] = '{serve: 1'b0, tick: 1'b1, ex: 320, ey: 240, est: 1};
    tbl[4] = '{serve: 1'b1, tick: 1'b0, ex: 320, ey: 240, est: 1};
    tbl[5] = '{serve: 1'b0, tick: 1'b1, ex: 324, ey: 244, est: 1};

    reset = 1'b0;
    tick = 1'b0;
    serve = 1'b0;
    paddle_y_left = 10'd0;
    paddle_y_right = 10'd0;
    #12;
    chk("reset_state", 316, 236, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].serve, tbl[i].tick);
      chk($sformatf("table_%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].est, 0, 0);
    end

    // Rightward flight past a paddle parked at the top: bottom bounce, then miss.
    run(76);
    chk("right_approach", 628, 396, 1, 0, 0);
    chk_no_miss("right_approach_no_miss");
    cyc(1'b0, 1'b1);
    chk("miss_right", 632, 392, 2, 0, 1);

    // Hold in SCORED for 60 ticks while serve is held high.
    cyc(1'b1, 1'b1);
    chk("miss_pulse_end", 632, 392, 2, 0, 0);
    for (int i = 0; i < 57; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("hold_59", 632, 392, 2, 0, 0);
    cyc(1'b0, 1'b1);
    chk("hold_done", 316, 236, 0, 0, 0);

    // Second serve goes left and is returned by the left paddle.
    cyc(1'b1, 1'b0);
    chk("serve2", 316, 236, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("serve2_left", 312, 240, 1, 0, 0);
    paddle_y_left = 10'd400;
    run(71);
    chk("left_approach", 28, 420, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("left_hit", 24, 416, 1, 0, 0);
    run(103);
    chk("near_top", 436, 4, 1, 0, 0);
    chk_no_miss("left_hit_no_miss");
    cyc(1'b0, 1'b1);
    chk("top_wall", 440, 0, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("top_bounce", 444, 4, 1, 0, 0);

    // Right paddle return.
    paddle_y_right = 10'd130;
    run(40);
    chk("right_paddle_approach", 604, 164, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("right_hit", 608, 168, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("after_right_hit", 604, 172, 1, 0, 0);

    // Leftward flight with the left paddle out of the way: bottom wall, then miss.
    paddle_y_left = 10'd0;
    run(75);
    chk("bottom_wall", 304, 472, 1, 0, 0);
    run(75);
    chk("left_edge", 4, 172, 1, 0, 0);
    chk_no_miss("left_run_no_miss");
    cyc(1'b0, 1'b1);
    chk("miss_left", 0, 168, 2, 1, 0);

    // Asynchronous reset during the miss pulse.
    #2;
    reset = 1'b0;
    #1;
    chk("reset_scored", 316, 236, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("serve3_right", 320, 240, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("serve3_move", 324, 244, 1, 0, 0);

    // Reset mid-PLAY restores serve direction to right.
    #2;
    reset = 1'b0;
    #1;
    chk("reset_play", 316, 236, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b1, 1'b1);
    chk("serve_with_tick", 316, 236, 1, 0, 0);
    cyc(1'b0, 1'b1);
    chk("serve_dir_reset", 320, 240, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
